// File: rtl/bidir_shift_engine.sv
// rtl/bidir_shift_engine.sv - bidirectional bit/symbol shift register with autonomous burst mode
// Optional feature macro: SHIFT_ROTATE_EN (adds rotate input; shifted-out bits wrap around)
module bidir_shift_engine #(
    parameter int  WIDTH = 26,
    parameter int  SYM_W = 2,
    localparam int NSYM  = WIDTH / SYM_W,
    localparam int LEN_W = $clog2(NSYM + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic [SYM_W-1:0] sym_in,
    input  logic [LEN_W-1:0] burst_len,
`ifdef SHIFT_ROTATE_EN
    input  logic             rotate,
`endif
    output logic [WIDTH-1:0] q,
    output logic [SYM_W-1:0] sym_out_left,
    output logic [SYM_W-1:0] sym_out_right,
    output logic             busy,
    output logic             done
);

    generate
        if (WIDTH % SYM_W != 0) begin : g_bad_width
            $error("bidir_shift_engine: WIDTH must be a multiple of SYM_W");
        end
    endgenerate

    localparam logic [LEN_W-1:0] NSYM_L = LEN_W'(NSYM);

    // Encoding keeps busy/done as single state flops, so the decodes cannot glitch.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BURST = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] count;
    logic             dir_right;
    logic             rot;
    logic [LEN_W-1:0] len_clamped;

`ifdef SHIFT_ROTATE_EN
    assign rot = rotate;
`else
    assign rot = 1'b0;
`endif

    assign len_clamped = (burst_len > NSYM_L) ? NSYM_L : burst_len;

    function automatic logic [WIDTH-1:0] bit_shift(input logic [WIDTH-1:0] v, input logic right,
                                                   input logic fill, input logic wrap);
        if (right)
            return {(wrap ? v[0] : fill), v[WIDTH-1:1]};
        else
            return {v[WIDTH-2:0], (wrap ? v[WIDTH-1] : fill)};
    endfunction

    function automatic logic [WIDTH-1:0] sym_shift(input logic [WIDTH-1:0] v, input logic right,
                                                   input logic [SYM_W-1:0] fill, input logic wrap);
        if (right)
            return {(wrap ? v[SYM_W-1:0] : fill), v[WIDTH-1:SYM_W]};
        else
            return {v[WIDTH-SYM_W-1:0], (wrap ? v[WIDTH-1 -: SYM_W] : fill)};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q         <= '0;
            state     <= IDLE;
            count     <= '0;
            dir_right <= 1'b0;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    case (op)
                        3'b001: q <= bit_shift(q, 1'b0, sym_in[0], rot);
                        3'b010: q <= bit_shift(q, 1'b1, sym_in[0], rot);
                        3'b011: q <= d;
                        3'b100: q <= sym_shift(q, 1'b0, sym_in, rot);
                        3'b101: q <= sym_shift(q, 1'b1, sym_in, rot);
                        3'b110, 3'b111: begin
                            // Start edge only arms the burst; the first shift happens next edge.
                            count     <= len_clamped;
                            dir_right <= op[0];
                            state     <= (len_clamped != '0) ? BURST : DONE;
                        end
                        default: ;
                    endcase
                end
                BURST: begin
                    q     <= sym_shift(q, dir_right, sym_in, rot);
                    count <= count - 1'b1;
                    if (count == LEN_W'(1))
                        state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy          = state[0];
    assign done          = state[1];
    assign sym_out_left  = q[WIDTH-1 -: SYM_W];
    assign sym_out_right = q[SYM_W-1:0];

endmodule
